// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and stack-op encoding for reg_file_stack
package reg_file_pkg;
  localparam int ADDR_ZERO = 0;
  localparam int RA_ADDR   = 1;
  localparam int SP_ADDR   = 3;
  localparam int SP_INIT   = 25;
  localparam int SP_LIMIT  = 0;
  localparam int SP_STEP   = 1;
  typedef enum logic [1:0] {NONE = 2'd0, PUSH = 2'd1, POP = 2'd2, BOTH = 2'd3} stack_op_t;
endpackage

// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit: combinational SP update with bound checks and ovf/unf set pulses
module stack_ptr_unit
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SP_INIT  = reg_file_pkg::SP_INIT,
  parameter int SP_LIMIT = reg_file_pkg::SP_LIMIT,
  parameter int SP_STEP  = reg_file_pkg::SP_STEP
) (
  input  logic [DATA_W-1:0] sp,
  input  logic              push_en,
  input  logic              pop_en,
  output logic [DATA_W-1:0] sp_next,
  output logic              sp_we,
  output logic              ovf_set,
  output logic              unf_set
);
  stack_op_t op;
  logic can_push, can_pop;
  assign op       = stack_op_t'({pop_en, push_en});
  assign can_push = sp > DATA_W'(SP_LIMIT);
  assign can_pop  = sp < DATA_W'(SP_INIT);
  assign sp_next  = (op == PUSH) ? sp - DATA_W'(SP_STEP) : sp + DATA_W'(SP_STEP);
  assign sp_we    = (op == PUSH && can_push) || (op == POP && can_pop);
  assign ovf_set  = op == PUSH && !can_push;
  assign unf_set  = op == POP && !can_pop;
endmodule

// File: rtl/reg_file_stack.sv
// reg_file_stack: register file with link port and bounded stack pointer; REG_FILE_STACK_BYPASS_EN enables write-to-read forwarding
module reg_file_stack
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RA_ADDR  = reg_file_pkg::RA_ADDR,
  parameter int SP_ADDR  = reg_file_pkg::SP_ADDR,
  parameter int SP_INIT  = reg_file_pkg::SP_INIT,
  parameter int SP_LIMIT = reg_file_pkg::SP_LIMIT,
  parameter int SP_STEP  = reg_file_pkg::SP_STEP
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic              push_en,
  input  logic              pop_en,
  input  logic              flag_clr,
  output logic [DATA_W-1:0] sp_o,
  output logic              stack_ovf,
  output logic              stack_unf
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(ADDR_ZERO);
  localparam logic [ADDR_W-1:0] A_RA   = ADDR_W'(RA_ADDR);
  localparam logic [ADDR_W-1:0] A_SP   = ADDR_W'(SP_ADDR);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] sp_next;
  logic sp_we, ovf_set, unf_set;
  stack_ptr_unit #(
    .DATA_W(DATA_W), .SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT), .SP_STEP(SP_STEP)
  ) u_sp (
    .sp(regs[SP_ADDR]), .push_en(push_en), .pop_en(pop_en),
    .sp_next(sp_next), .sp_we(sp_we), .ovf_set(ovf_set), .unf_set(unf_set)
  );
  // register writes: later assignments win, giving stack op > link > general priority
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == SP_ADDR) ? DATA_W'(SP_INIT) : '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (wr_en && wr_addr != A_ZERO) regs[wr_addr] <= wr_data;
      if (link_en && A_RA != A_ZERO) regs[RA_ADDR] <= link_data;
      if (sp_we && A_SP != A_ZERO) regs[SP_ADDR] <= sp_next;
      stack_ovf <= ovf_set | (stack_ovf & ~flag_clr);
      stack_unf <= unf_set | (stack_unf & ~flag_clr);
    end
  end
`ifdef REG_FILE_STACK_BYPASS_EN
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs[a];
    if (wr_en && wr_addr == a) v = wr_data;
    if (link_en && a == A_RA) v = link_data;
    if (sp_we && a == A_SP) v = sp_next;
    return (a == A_ZERO) ? '0 : v;
  endfunction
`else
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    return (a == A_ZERO) ? '0 : regs[a];
  endfunction
`endif
  // read ports and SP mirror
  always_comb begin
    rd_data_a = rd_val(rd_addr_a);
    rd_data_b = rd_val(rd_addr_b);
    sp_o      = rd_val(A_SP);
  end
endmodule

// File: tb/tb_reg_file_stack.sv
// tb_reg_file_stack: scoreboard-driven self-checking bench for reg_file_stack
module tb_reg_file_stack;
  logic clock = 1'b0;
  logic reset_n;
  logic [5:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data, link_data, sp_o;
  logic wr_en, link_en, push_en, pop_en, flag_clr, stack_ovf, stack_unf;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  reg_file_stack #(.DATA_W(32), .ADDR_W(6), .RA_ADDR(1), .SP_ADDR(3),
                   .SP_INIT(25), .SP_LIMIT(23), .SP_STEP(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data),
    .push_en(push_en), .pop_en(pop_en), .flag_clr(flag_clr),
    .sp_o(sp_o), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  task automatic step();
    @(posedge clock);
    #1;
    wr_en = 0; link_en = 0; push_en = 0; pop_en = 0; flag_clr = 0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; wr_en = 1; wr_addr = 3; wr_data = 32'h77; push_en = 1; flag_clr = 1;
    step();
    reset_n = 1; rd_addr_a = 3; rd_addr_b = 5;
    #1;
    exp_q.push_back(25); exp_q.push_back(0); exp_q.push_back(25); exp_q.push_back(0); exp_q.push_back(0);
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_a !== e) $display("FAIL reset_rd_a got %h want %h", rd_data_a, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_b !== e) $display("FAIL reset_rd_b got %h want %h", rd_data_b, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if (sp_o !== e) $display("FAIL reset_sp got %h want %h", sp_o, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_ovf} !== e) $display("FAIL reset_ovf got %b want %0d", stack_ovf, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_unf} !== e) $display("FAIL reset_unf got %b want %0d", stack_unf, e); else pass_cnt++;
  endtask

  task automatic test_write();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    step();
    rd_addr_a = 5; #1;
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_a !== e) $display("FAIL write_5 got %h want %h", rd_data_a, e); else pass_cnt++;
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; exp_q.push_back(0);
    step();
    rd_addr_b = 0; #1;
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_b !== e) $display("FAIL write_r0 got %h want %h", rd_data_b, e); else pass_cnt++;
  endtask

  task automatic test_stack();
    logic [2:0] ops [5];
    logic [31:0] sps [5];
    ops = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b010};
    sps = '{32'd24, 32'd23, 32'd24, 32'd25, 32'd25};
    for (int i = 0; i < 5; i++) begin
      {pop_en, push_en} = ops[i][1:0]; exp_q.push_back(sps[i]);
      step();
      total_cnt++; e = exp_q.pop_front();
      if (sp_o !== e) $display("FAIL stack_seq%0d got %0d want %0d", i, sp_o, e); else pass_cnt++;
    end
    exp_q.push_back(1);
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_unf} !== e) $display("FAIL stack_unf got %b want %0d", stack_unf, e); else pass_cnt++;
    flag_clr = 1; exp_q.push_back(0);
    step();
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_unf} !== e) $display("FAIL stack_unf_clr got %b want %0d", stack_unf, e); else pass_cnt++;
  endtask

  task automatic test_limit();
    push_en = 1; step(); push_en = 1; step();
    exp_q.push_back(23);
    total_cnt++; e = exp_q.pop_front();
    if (sp_o !== e) $display("FAIL limit_sp got %0d want %0d", sp_o, e); else pass_cnt++;
    push_en = 1; exp_q.push_back(23); exp_q.push_back(1);
    step();
    total_cnt++; e = exp_q.pop_front();
    if (sp_o !== e) $display("FAIL limit_refused_sp got %0d want %0d", sp_o, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_ovf} !== e) $display("FAIL limit_ovf got %b want %0d", stack_ovf, e); else pass_cnt++;
    push_en = 1; pop_en = 1; exp_q.push_back(23); exp_q.push_back({30'b0, 2'b10});
    step();
    total_cnt++; e = exp_q.pop_front();
    if (sp_o !== e) $display("FAIL both_sp got %0d want %0d", sp_o, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if ({30'b0, stack_ovf, stack_unf} !== e) $display("FAIL both_flags got %b%b want %b", stack_ovf, stack_unf, e[1:0]); else pass_cnt++;
    flag_clr = 1; push_en = 1; exp_q.push_back(1);
    step();
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_ovf} !== e) $display("FAIL clr_vs_ovf got %b want %0d", stack_ovf, e); else pass_cnt++;
    flag_clr = 1; exp_q.push_back(0);
    step();
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_ovf} !== e) $display("FAIL ovf_clr got %b want %0d", stack_ovf, e); else pass_cnt++;
  endtask

  task automatic test_collision();
    pop_en = 1; step(); pop_en = 1; step();
    wr_en = 1; wr_addr = 1; wr_data = 32'h10; link_en = 1; link_data = 32'h20; exp_q.push_back(32'h20);
    step();
    rd_addr_a = 1; #1;
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_a !== e) $display("FAIL link_wins got %h want %h", rd_data_a, e); else pass_cnt++;
    wr_en = 1; wr_addr = 3; wr_data = 32'h50; push_en = 1; exp_q.push_back(24);
    step();
    total_cnt++; e = exp_q.pop_front();
    if (sp_o !== e) $display("FAIL push_beats_wr got %h want %h", sp_o, e); else pass_cnt++;
    push_en = 1; step();
    wr_en = 1; wr_addr = 3; wr_data = 32'h50; push_en = 1; exp_q.push_back(32'h50); exp_q.push_back(1);
    step();
    total_cnt++; e = exp_q.pop_front();
    if (sp_o !== e) $display("FAIL wr_after_refuse got %h want %h", sp_o, e); else pass_cnt++;
    total_cnt++; e = exp_q.pop_front();
    if ({31'b0, stack_ovf} !== e) $display("FAIL refuse_ovf got %b want %0d", stack_ovf, e); else pass_cnt++;
  endtask

  task automatic test_forward();
    rd_addr_a = 7; wr_en = 1; wr_addr = 7; wr_data = 32'h1234;
`ifdef REG_FILE_STACK_BYPASS_EN
    exp_q.push_back(32'h1234);
`else
    exp_q.push_back(0);
`endif
    exp_q.push_back(32'h1234);
    #1;
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_a !== e) $display("FAIL fwd_same got %h want %h", rd_data_a, e); else pass_cnt++;
    step();
    total_cnt++; e = exp_q.pop_front();
    if (rd_data_a !== e) $display("FAIL fwd_next got %h want %h", rd_data_a, e); else pass_cnt++;
  endtask

  initial begin
    reset_n = 1; rd_addr_a = 0; rd_addr_b = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    link_en = 0; link_data = 0; push_en = 0; pop_en = 0; flag_clr = 0;
    test_reset();
    test_write();
    test_stack();
    test_limit();
    test_collision();
    test_forward();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_file_stack.md
Name: reg_file_stack

Overview:
- Parametrised successor to the single-cycle register bank.
- Provides NUM_REGS x DATA_W registers with two asynchronous read ports, one general write port and a dedicated link (return-address) write port.
- Includes an internal stack-pointer unit that computes push/pop updates itself, enforces stack bounds, and raises sticky overflow/underflow flags.
- Sits in the decode stage; feeds the ALU operand muxes and the data-memory address path (sp_o).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 6, register address width; NUM_REGS = 2**ADDR_W
RA_ADDR, 1, index of the link register
SP_ADDR, 3, index of the stack-pointer register
SP_INIT, 25, stack-pointer value after reset (empty-stack top)
SP_LIMIT, 0, lowest legal stack-pointer value (full stack)
SP_STEP, 1, amount SP moves per push/pop

Ports:
clock  in  1  system clock, all state updates on the rising edge
reset_n  in  1  synchronous, active-low reset
rd_addr_a  in  ADDR_W  read port A address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_addr_b  in  ADDR_W  read port B address
rd_data_b  out  DATA_W  read port B data (combinational)
wr_en  in  1  general write enable
wr_addr  in  ADDR_W  general write address
wr_data  in  DATA_W  general write data
link_en  in  1  write link_data into RA_ADDR
link_data  in  DATA_W  return address (PC+4)
push_en  in  1  stack push: SP -= SP_STEP
pop_en  in  1  stack pop: SP += SP_STEP
flag_clr  in  1  clear sticky stack flags
sp_o  out  DATA_W  current SP register contents
stack_ovf  out  1  sticky: push refused at SP_LIMIT
stack_unf  out  1  sticky: pop refused at SP_INIT

Behaviour:
- Reset: on a rising edge with reset_n=0, every register is set to 0 except SP_ADDR, which is set to SP_INIT. stack_ovf=0, stack_unf=0. Reset overrides every write, push, pop and flag_clr in the same cycle.
- Reads: rd_data_x = reg[rd_addr_x] combinationally. Address 0 always reads 0.
- Register 0: writes to it from any source are discarded.
- General write: when wr_en=1, reg[wr_addr] <= wr_data at the rising edge. Write latency is 1 cycle; the new value is visible to reads in the next cycle.
- Link write: when link_en=1, reg[RA_ADDR] <= link_data. If wr_en also targets RA_ADDR in the same cycle, the link write wins.
- Stack unit, one operation per cycle:
  - push only: if SP > SP_LIMIT then SP <= SP - SP_STEP; else SP unchanged and stack_ovf <= 1.
  - pop only: if SP < SP_INIT then SP <= SP + SP_STEP; else SP unchanged and stack_unf <= 1.
  - push and pop together: treated as a no-op. SP unchanged, no flag change.
  - Bound checks are unsigned compares. SP never wraps.
- SP priority: an accepted push/pop beats a general write to SP_ADDR. A refused push/pop or a push+pop no-op lets the general write to SP_ADDR proceed.
- Flags: flag_clr=1 clears both flags. A new overflow or underflow event in the same cycle as flag_clr wins, so the flag reads 1 next cycle.
- sp_o mirrors reg[SP_ADDR] and reflects the value after the last edge.

Optional Feature:
- Macro: REG_FILE_STACK_BYPASS_EN.
- Defined: write-to-read forwarding. If a read address matches an address being written this cycle, rd_data returns the value that will be written, using the same priority rules (link > general for RA; accepted stack op > general for SP; address 0 still reads 0). sp_o also forwards the SP next value.
- Undefined: reads return pre-edge contents only.

Decomposition:
- Package reg_file_pkg holds:
  - default constants ADDR_ZERO=0, RA_ADDR, SP_ADDR, SP_INIT, SP_LIMIT, SP_STEP;
  - a stack_op_t enumeration (NONE, PUSH, POP, BOTH).
- One sub-module, stack_ptr_unit. It takes the current SP, push_en and pop_en, and produces the SP next value, an SP write-accept signal and the ovf/unf set pulses. It is purely combinational; the flags are registered in the parent.

Test Plan:
1. Reset: hold reset_n=0 for 1 edge, then release. Require rd_addr_a=3 -> 25, rd_addr_b=5 -> 0, sp_o=25, both flags 0.
2. Write addr 5 with 0xDEADBEEF. Next cycle rd_addr_a=5 -> 0xDEADBEEF. Write addr 0 with 0xFFFFFFFF; read addr 0 -> 0.
3. Stack sequence push, push, pop from reset. Require sp_o 24, 23, 24. Then pop twice: sp_o=25, then stack_unf=1 with sp_o still 25. Assert flag_clr -> stack_unf=0.
4. With SP_LIMIT=23: push twice -> sp_o=23. Third push -> stack_ovf=1, sp_o=23. Push and pop together -> sp_o=23 and no further flag change.
5. Collisions in one cycle:
   - wr_en addr 1 data 0x10 plus link_en data 0x20 -> reg1=0x20.
   - wr_en addr 3 data 0x50 plus push at SP=25 -> sp_o=24.
   - wr_en addr 3 data 0x50 plus push with SP already at SP_LIMIT -> sp_o=0x50 and stack_ovf=1.
6. Forwarding, same-cycle write and read of addr 7 (old 0, new 0x1234). With REG_FILE_STACK_BYPASS_EN: rd_data_a=0x1234 in that cycle. Without it: 0 in that cycle, 0x1234 the next.
